// File: rtl/axis_crc32_check.sv
// Receive-side CRC-32 checker for an 8-bit AXI-stream frame ending in a 4-byte LSB-first FCS.
// Strips the FCS and tags the final payload beat bad on CRC mismatch or upstream error.

module lfsr #(
  parameter int          LFSR_WIDTH = 32,
  parameter logic [31:0] LFSR_POLY  = 32'h04c11db7,
  parameter bit          REVERSE    = 1'b1,
  parameter int          DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [LFSR_WIDTH-1:0] state_in,
  output logic [LFSR_WIDTH-1:0] state_out
);

  logic [LFSR_WIDTH-1:0] poly_fwd;
  logic [LFSR_WIDTH-1:0] poly_rev;

  assign poly_fwd = LFSR_POLY[LFSR_WIDTH-1:0];

  generate
    for (genvar gi = 0; gi < LFSR_WIDTH; gi++) begin : g_poly_rev
      assign poly_rev[gi] = poly_fwd[LFSR_WIDTH-1-gi];
    end
  endgenerate

  // Galois form, one data bit per step; reflected mode shifts right and eats bits LSB first.
  always_comb begin
    logic [LFSR_WIDTH-1:0] s;
    logic                  fb;
    s  = state_in;
    fb = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (REVERSE) begin
        fb = s[0] ^ data_in[i];
        s  = s >> 1;
        if (fb) s = s ^ poly_rev;
      end else begin
        fb = s[LFSR_WIDTH-1] ^ data_in[DATA_WIDTH-1-i];
        s  = s << 1;
        if (fb) s = s ^ poly_fwd;
      end
    end
    state_out = s;
  end

endmodule

module axis_crc32_check #(
  parameter logic [31:0] LFSR_POLY   = 32'h04c11db7,
  parameter logic [31:0] CRC_INIT    = 32'hffffffff,
  parameter logic [31:0] CRC_RESIDUE = 32'hdebb20e3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tuser,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  output logic       status_good,
  output logic       status_bad,
  output logic       status_short
);

  logic [31:0] crc_reg;
  logic [31:0] crc_next;
  logic [31:0] hold_reg;
  logic [2:0]  count_reg;
  logic        err_reg;
  logic [7:0]  data_reg;
  logic        valid_reg;
  logic        last_reg;
  logic        user_reg;
  logic        good_reg;
  logic        bad_reg;
  logic        short_reg;
  logic        accept;
  logic        frame_bad;

  lfsr #(
    .LFSR_WIDTH(32),
    .LFSR_POLY (LFSR_POLY),
    .REVERSE   (1'b1),
    .DATA_WIDTH(8)
  ) crc_lfsr (
    .data_in  (s_axis_tdata),
    .state_in (crc_reg),
    .state_out(crc_next)
  );

  assign s_axis_tready = !rst && (!valid_reg || m_axis_tready);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign frame_bad     = (crc_next != CRC_RESIDUE) | err_reg | s_axis_tuser;

  assign m_axis_tdata  = data_reg;
  assign m_axis_tvalid = valid_reg;
  assign m_axis_tlast  = last_reg;
  assign m_axis_tuser  = user_reg;
  assign status_good   = good_reg;
  assign status_bad    = bad_reg;
  assign status_short  = short_reg;

  // The four most recent bytes are held back because they may turn out to be the FCS.
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_reg   <= CRC_INIT;
      hold_reg  <= 32'd0;
      count_reg <= 3'd0;
      err_reg   <= 1'b0;
      data_reg  <= 8'd0;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
      user_reg  <= 1'b0;
      good_reg  <= 1'b0;
      bad_reg   <= 1'b0;
      short_reg <= 1'b0;
    end else begin
      good_reg  <= 1'b0;
      bad_reg   <= 1'b0;
      short_reg <= 1'b0;
      if (valid_reg && m_axis_tready) begin
        valid_reg <= 1'b0;
      end
      if (accept) begin
        if (!s_axis_tlast) begin
          crc_reg  <= crc_next;
          err_reg  <= err_reg | s_axis_tuser;
          hold_reg <= {hold_reg[23:0], s_axis_tdata};
          if (count_reg == 3'd4) begin
            data_reg  <= hold_reg[31:24];
            valid_reg <= 1'b1;
            last_reg  <= 1'b0;
            user_reg  <= 1'b0;
          end else begin
            count_reg <= count_reg + 3'd1;
          end
        end else begin
          crc_reg   <= CRC_INIT;
          err_reg   <= 1'b0;
          hold_reg  <= 32'd0;
          count_reg <= 3'd0;
          if (count_reg == 3'd4) begin
            data_reg  <= hold_reg[31:24];
            valid_reg <= 1'b1;
            last_reg  <= 1'b1;
            user_reg  <= frame_bad;
            good_reg  <= !frame_bad;
            bad_reg   <= frame_bad;
          end else begin
            short_reg <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_crc32_check.sv
// Directed bench for axis_crc32_check: good/bad/short frames, stalls, upstream error, mid-frame reset.

module tb_axis_crc32_check;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_axis_tdata = 8'd0;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic       s_axis_tlast = 1'b0;
  logic       s_axis_tuser = 1'b0;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 1'b1;
  logic       m_axis_tlast;
  logic       m_axis_tuser;
  logic       status_good;
  logic       status_bad;
  logic       status_short;

  axis_crc32_check dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tuser (s_axis_tuser),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tuser (m_axis_tuser),
    .status_good  (status_good),
    .status_bad   (status_bad),
    .status_short (status_short)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int first_cyc = -1;
  int fifth_cyc = -2;
  int n_good = 0;
  int n_bad = 0;
  int n_short = 0;
  bit tog_en = 1'b0;
  int tog_ph = 0;
  bit stall_prev = 1'b0;
  logic [7:0] stall_data = 8'd0;
  logic [9:0] beats[$];
  logic [7:0] cur[16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready pattern 1,0,0,1 when enabled.
  always @(posedge clk) begin
    #1;
    if (tog_en) begin
      m_axis_tready = !((tog_ph % 4 == 1) || (tog_ph % 4 == 2));
      tog_ph++;
    end
  end

  always @(negedge clk) begin
    if (m_axis_tvalid && m_axis_tready) begin
      if (beats.size() == 0) first_cyc = cyc;
      beats.push_back({m_axis_tlast, m_axis_tuser, m_axis_tdata});
    end
    if (status_good)  n_good++;
    if (status_bad)   n_bad++;
    if (status_short) n_short++;
    if (stall_prev && !rst) begin
      check("stall_valid_held", {31'd0, m_axis_tvalid}, 32'd1);
      check("stall_data_held", {24'd0, m_axis_tdata}, {24'd0, stall_data});
    end
    check("tready_rule", {31'd0, s_axis_tready},
          {31'd0, (!rst && !(m_axis_tvalid && !m_axis_tready))});
    stall_prev = m_axis_tvalid && !m_axis_tready;
    stall_data = m_axis_tdata;
  end

  task automatic load_good();
    cur[0] = 8'h31; cur[1] = 8'h32; cur[2] = 8'h33; cur[3] = 8'h34; cur[4] = 8'h35;
    cur[5] = 8'h36; cur[6] = 8'h37; cur[7] = 8'h38; cur[8] = 8'h39;
    cur[9] = 8'h26; cur[10] = 8'h39; cur[11] = 8'hF4; cur[12] = 8'hCB;
  endtask

  // stop > 0 sends only that many bytes with no tlast.
  task automatic send_frame(input int len, input int user_idx, input bit gaps, input int stop);
    int n;
    bit acc;
    int budget;
    n = (stop > 0) ? stop : len;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          s_axis_tvalid = 1'b0;
          @(posedge clk); #1;
        end
      end
      s_axis_tdata  = cur[i];
      s_axis_tlast  = (i == len - 1) && (stop == 0);
      s_axis_tuser  = (i == user_idx);
      s_axis_tvalid = 1'b1;
      acc = 1'b0;
      budget = 0;
      while (!acc && budget < 200) begin
        @(negedge clk);
        acc = s_axis_tready;
        @(posedge clk); #1;
        budget++;
      end
      if (!acc) check("accept_timeout", 32'd0, 32'd1);
      if (i == 4) fifth_cyc = cyc;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic clear_frame();
    beats.delete();
    first_cyc = -1;
    n_good = 0;
    n_bad = 0;
    n_short = 0;
  endtask

  task automatic check_frame(input string tag, input int exp_len, input bit exp_user,
                             input int exp_good, input int exp_bad, input int exp_short);
    int nb;
    repeat (10) @(posedge clk);
    #1;
    nb = beats.size();
    check({tag, "_beats"}, nb, exp_len);
    for (int i = 0; i < nb && i < exp_len; i++) begin
      check($sformatf("%s_data%0d", tag, i), {24'd0, beats[i][7:0]}, {24'd0, cur[i]});
      check($sformatf("%s_last%0d", tag, i), {31'd0, beats[i][9]}, {31'd0, (i == exp_len - 1)});
      if (i == exp_len - 1) check({tag, "_tuser"}, {31'd0, beats[i][8]}, {31'd0, exp_user});
    end
    check({tag, "_good"}, n_good, exp_good);
    check({tag, "_bad"}, n_bad, exp_bad);
    check({tag, "_short"}, n_short, exp_short);
    $display("frame %s: %0d beats, good=%0d bad=%0d short=%0d", tag, nb, n_good, n_bad, n_short);
    clear_frame();
  endtask

  initial begin
    int tl;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tready", {31'd0, s_axis_tready}, 32'd0);
    check("rst_outs", {20'd0, m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata,
                       status_good, status_bad, status_short}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_frame();

    // Good frame, ready held high; payload starts the cycle the 5th byte is registered.
    load_good();
    send_frame(13, -1, 1'b0, 0);
    check("good_latency", first_cyc, fifth_cyc);
    check_frame("good", 9, 1'b0, 1, 0, 0);

    load_good();
    cur[4] = 8'h75;
    send_frame(13, -1, 1'b0, 0);
    check_frame("corrupt", 9, 1'b1, 0, 1, 0);

    cur[0] = 8'h26; cur[1] = 8'h39; cur[2] = 8'hF4; cur[3] = 8'hCB;
    send_frame(4, -1, 1'b0, 0);
    cur[0] = 8'hAA; cur[1] = 8'hBB;
    send_frame(2, -1, 1'b0, 0);
    check_frame("short", 0, 1'b0, 0, 0, 2);
    load_good();
    send_frame(13, -1, 1'b0, 0);
    check_frame("after_short", 9, 1'b0, 1, 0, 0);

    tog_en = 1'b1;
    load_good();
    send_frame(13, -1, 1'b1, 0);
    check_frame("stalled", 9, 1'b0, 1, 0, 0);
    tog_en = 1'b0;
    m_axis_tready = 1'b1;
    repeat (2) @(posedge clk); #1;

    load_good();
    send_frame(13, 2, 1'b0, 0);
    check_frame("upstream_err", 9, 1'b1, 0, 1, 0);
    send_frame(13, -1, 1'b0, 0);
    check_frame("err_cleared", 9, 1'b0, 1, 0, 0);

    // Reset after byte 7 of a frame.
    load_good();
    send_frame(13, -1, 1'b0, 7);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_tready", {31'd0, s_axis_tready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_outs", {20'd0, m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata,
                          status_good, status_bad, status_short}, 32'd0);
    repeat (4) @(posedge clk); #1;
    tl = 0;
    foreach (beats[i]) if (beats[i][9]) tl++;
    check("midrst_no_tlast", tl, 0);
    $display("frame midrst: %0d partial beats, tlast count %0d", beats.size(), tl);
    clear_frame();
    send_frame(13, -1, 1'b0, 0);
    check_frame("after_rst", 9, 1'b0, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
